// File: rtl/uncache_dresp_pkg.sv
// Shared types and constants for the uncached data-port responder.
package uncache_dresp_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdAddr = 3'd1,
    StRdData = 3'd2,
    StWrReq  = 3'd3,
    StWrResp = 3'd4,
    StDone   = 3'd5
  } uc_state_e;

  localparam logic [2:0] AxiSizeWord = 3'd2;
  localparam logic [3:0] UcAxiId     = 4'd1;

  function automatic logic in_flight(input uc_state_e st);
    return (st == StRdAddr) || (st == StRdData) || (st == StWrReq) || (st == StWrResp);
  endfunction

endpackage

// File: rtl/uncache_dresp.sv
// Uncached data_sram responder: turns each accepted core request into one single-beat AXI
// read or write and stalls the pipeline until the bus response returns.
module uncache_dresp
  import uncache_dresp_pkg::*;
#(
  parameter logic [3:0] AxiId = UcAxiId
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,

  input  logic        data_sram_en_i,
  input  logic [3:0]  data_sram_wen_i,
  input  logic [31:0] data_sram_addr_i,
  input  logic [31:0] data_sram_wdata_i,
  output logic [31:0] data_sram_rdata_o,
  output logic        stallreq_uncache_o,

  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [2:0]  arsize_o,
  output logic        arvalid_o,
  input  logic        arready_i,

  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o,

  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        awvalid_o,
  input  logic        awready_i,

  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,

  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  uc_state_e   state_q, state_d;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wen_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        flushed_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        aw_ok, w_ok;

  // Response IDs and codes carry no information for single-outstanding uncached traffic.
  logic unused_resp;
  assign unused_resp = ^{rid_i, rresp_i, bid_i, bresp_i};

  assign accept = (state_q == StIdle) && data_sram_en_i && !flush_i;
  assign aw_ok  = aw_done_q || awready_i;
  assign w_ok   = w_done_q || wready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (data_sram_wen_i == 4'd0) ? StRdAddr : StWrReq;
      end
      StRdAddr: if (arready_i) state_d = StRdData;
      StRdData: if (rvalid_i) state_d = StDone;
      StWrReq: begin
        if (aw_ok && w_ok) begin
          state_d   = StWrResp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_ok;
          w_done_d  = w_ok;
        end
      end
      StWrResp: if (bvalid_i) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= '0;
      flushed_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        addr_q    <= data_sram_addr_i[31:2];
        wdata_q   <= data_sram_wdata_i;
        wen_q     <= data_sram_wen_i;
        flushed_q <= 1'b0;
      end else if (in_flight(state_q) && flush_i) begin
        flushed_q <= 1'b1;
      end
      // A flushed load still drains the R beat but must not disturb the returned data.
      if ((state_q == StRdData) && rvalid_i && !flushed_q && !flush_i) begin
        rdata_q <= rdata_i;
      end
    end
  end

  always_comb begin
    stallreq_uncache_o = accept || in_flight(state_q);
    data_sram_rdata_o  = rdata_q;

    arid_o    = AxiId;
    araddr_o  = {addr_q, 2'b00};
    arsize_o  = AxiSizeWord;
    arvalid_o = (state_q == StRdAddr);
    rready_o  = (state_q == StRdData);

    awid_o    = AxiId;
    awaddr_o  = {addr_q, 2'b00};
    awsize_o  = AxiSizeWord;
    awvalid_o = (state_q == StWrReq) && !aw_done_q;
    wdata_o   = wdata_q;
    wstrb_o   = wen_q;
    wlast_o   = 1'b1;
    wvalid_o  = (state_q == StWrReq) && !w_done_q;
    bready_o  = (state_q == StWrResp);
  end

endmodule

// File: tb/tb_uncache_dresp.sv
// Directed self-checking bench for uncache_dresp with a cycle-level AXI slave per scenario.
module tb_uncache_dresp;

  logic        clk, rst_n, flush, en;
  logic [3:0]  wen;
  logic [31:0] addr, wdata_in, rdata_out;
  logic        stall;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  rresp, bresp;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;

  uncache_dresp dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .data_sram_en_i(en), .data_sram_wen_i(wen), .data_sram_addr_i(addr),
    .data_sram_wdata_i(wdata_in), .data_sram_rdata_o(rdata_out), .stallreq_uncache_o(stall),
    .arid_o(arid), .araddr_o(araddr), .arsize_o(arsize), .arvalid_o(arvalid),
    .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .awid_o(awid), .awaddr_o(awaddr), .awsize_o(awsize), .awvalid_o(awvalid),
    .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one load; inputs change at posedge+1, outputs sampled at posedge+2.
  task automatic run_load(input logic [31:0] a, input logic [31:0] d, input int ar_dly,
                          input int r_dly, input int flush_at, output int stall_cyc,
                          output logic [31:0] ar_seen, output int ar_hs, output bit bad_attr,
                          output bit tmo);
    int ar_wait, r_wait;
    bit done;
    stall_cyc = 0; ar_seen = '0; ar_hs = 0; bad_attr = 0; tmo = 1; ar_wait = 0; r_wait = 0;
    en = 1'b1; wen = 4'd0; addr = a;
    for (int cyc = 0; cyc < 40; cyc++) begin
      flush = (cyc == flush_at);
      #1;
      if (stall) stall_cyc++;
      if (arvalid) begin
        ar_seen = araddr;
        if (arsize !== 3'd2 || arid !== 4'd1) bad_attr = 1;
        arready = (ar_wait >= ar_dly);
        if (arready) ar_hs++; else ar_wait++;
      end else arready = 1'b0;
      if (rready) begin
        rvalid = (r_wait >= r_dly);
        rdata  = d;
        if (!rvalid) r_wait++;
      end else rvalid = 1'b0;
      done = (cyc > 0) && !stall;
      @(posedge clk); #1;
      if (done) begin tmo = 0; break; end
    end
    arready = 1'b0; rvalid = 1'b0; flush = 1'b0;
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output int stall_cyc, output logic [31:0] aw_seen,
                           output logic [31:0] w_seen, output logic [3:0] strb_seen,
                           output int aw_hs, output int w_hs, output bit bad_attr,
                           output bit tmo);
    int aw_wait, w_wait, b_wait;
    bit done;
    stall_cyc = 0; aw_seen = '0; w_seen = '0; strb_seen = '0; aw_hs = 0; w_hs = 0;
    bad_attr = 0; tmo = 1; aw_wait = 0; w_wait = 0; b_wait = 0;
    en = 1'b1; wen = be; addr = a; wdata_in = d;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (stall) stall_cyc++;
      if (awvalid) begin
        aw_seen = awaddr;
        if (awsize !== 3'd2 || awid !== 4'd1) bad_attr = 1;
        awready = (aw_wait >= aw_dly);
        if (awready) aw_hs++; else aw_wait++;
      end else awready = 1'b0;
      if (wvalid) begin
        w_seen = wdata; strb_seen = wstrb;
        if (wlast !== 1'b1) bad_attr = 1;
        wready = (w_wait >= w_dly);
        if (wready) w_hs++; else w_wait++;
      end else wready = 1'b0;
      if (bready) begin
        bvalid = (b_wait >= b_dly);
        if (!bvalid) b_wait++;
      end else bvalid = 1'b0;
      done = (cyc > 0) && !stall;
      @(posedge clk); #1;
      if (done) begin tmo = 0; break; end
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      errors++; $display("FAIL reset_handshakes got %b exp 00000",
                         {arvalid, awvalid, wvalid, rready, bready});
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++;
    if (rdata_out !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp 00000000", rdata_out);
    end
  endtask

  task automatic test_load_basic();
    int sc, hs; logic [31:0] ar; bit bad, tmo;
    run_load(32'hBFAF_8004, 32'h1234_5678, 0, 0, -1, sc, ar, hs, bad, tmo);
    en = 1'b0;
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL load_basic_timeout got 1 exp 0"); end
    checks++;
    if (ar !== 32'hBFAF_8004) begin
      errors++; $display("FAIL load_basic_araddr got %h exp bfaf8004", ar);
    end
    checks++;
    if (sc != 3) begin errors++; $display("FAIL load_basic_stall got %0d exp 3", sc); end
    checks++;
    if (rdata_out !== 32'h1234_5678) begin
      errors++; $display("FAIL load_basic_rdata got %h exp 12345678", rdata_out);
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL load_basic_arsize_arid got 1 exp 0"); end
  endtask

  task automatic test_load_delayed();
    int sc, hs; logic [31:0] ar; bit bad, tmo;
    run_load(32'hBFAF_0013, 32'hCAFE_F00D, 2, 3, -1, sc, ar, hs, bad, tmo);
    en = 1'b0;
    checks++;
    if (ar !== 32'hBFAF_0010) begin
      errors++; $display("FAIL load_delay_araddr got %h exp bfaf0010", ar);
    end
    checks++;
    if (sc != 8 || hs != 1) begin
      errors++; $display("FAIL load_delay_stall_hs got %0d/%0d exp 8/1", sc, hs);
    end
    checks++;
    if (rdata_out !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL load_delay_rdata got %h exp cafef00d", rdata_out);
    end
  endtask

  task automatic test_store_byte();
    int sc, awh, wh; logic [31:0] aw, wd; logic [3:0] sb; bit bad, tmo;
    run_store(32'hBFAF_F002, 32'h00AB_0000, 4'b0100, 3, 0, 0, sc, aw, wd, sb, awh, wh, bad, tmo);
    en = 1'b0;
    checks++;
    if (aw !== 32'hBFAF_F000 || sb !== 4'b0100) begin
      errors++; $display("FAIL store_byte_awaddr_wstrb got %h/%b exp bfaff000/0100", aw, sb);
    end
    checks++;
    if (awh != 1 || wh != 1) begin
      errors++; $display("FAIL store_byte_handshakes got %0d/%0d exp 1/1", awh, wh);
    end
    checks++;
    if (sc != 6 || tmo) begin
      errors++; $display("FAIL store_byte_stall got %0d tmo %0d exp 6 tmo 0", sc, tmo);
    end
    checks++;
    if (rdata_out !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL store_keeps_rdata got %h exp cafef00d", rdata_out);
    end
  endtask

  task automatic test_store_same_cycle();
    int sc, awh, wh; logic [31:0] aw, wd; logic [3:0] sb; bit bad, tmo;
    run_store(32'hBFAF_0008, 32'hA5A5_5A5A, 4'hF, 0, 0, 5, sc, aw, wd, sb, awh, wh, bad, tmo);
    en = 1'b0;
    checks++;
    if (sc != 8 || tmo) begin
      errors++; $display("FAIL store_bdelay_stall got %0d tmo %0d exp 8 tmo 0", sc, tmo);
    end
    checks++;
    if (wd !== 32'hA5A5_5A5A || aw !== 32'hBFAF_0008) begin
      errors++; $display("FAIL store_same_payload got %h/%h exp a5a55a5a/bfaf0008", wd, aw);
    end
    checks++;
    if (awh != 1 || wh != 1 || bad) begin
      errors++; $display("FAIL store_same_hs_attr got %0d/%0d/%0d exp 1/1/0", awh, wh, bad);
    end
  endtask

  task automatic test_held_en();
    int sc, hs, extra; logic [31:0] ar; bit bad, tmo;
    run_load(32'hBFAF_8100, 32'h1111_2222, 0, 0, -1, sc, ar, hs, bad, tmo);
    en = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (arvalid || stall) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (hs != 1 || extra != 0) begin
      errors++; $display("FAIL held_en_single_read got hs %0d extra %0d exp 1 0", hs, extra);
    end
  endtask

  task automatic test_back_to_back();
    int sc1, sc2, hs1, hs2; logic [31:0] ar1, ar2; bit bad, tmo1, tmo2;
    run_load(32'hBFAF_8200, 32'h3333_4444, 0, 0, -1, sc1, ar1, hs1, bad, tmo1);
    run_load(32'hBFAF_8300, 32'h5555_6666, 0, 0, -1, sc2, ar2, hs2, bad, tmo2);
    en = 1'b0;
    checks++;
    if (ar2 !== 32'hBFAF_8300 || hs2 != 1 || tmo2) begin
      errors++; $display("FAIL b2b_second_read got %h hs %0d exp bfaf8300 hs 1", ar2, hs2);
    end
    checks++;
    if (sc1 != 3 || sc2 != 3) begin
      errors++; $display("FAIL b2b_stall got %0d/%0d exp 3/3", sc1, sc2);
    end
    checks++;
    if (rdata_out !== 32'h5555_6666) begin
      errors++; $display("FAIL b2b_rdata got %h exp 55556666", rdata_out);
    end
  endtask

  task automatic test_flush_idle();
    en = 1'b1; wen = 4'd0; addr = 32'hBFAF_8500; flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b exp 0", stall); end
    @(posedge clk); #1;
    en = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b0 || awvalid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_no_req got %b%b exp 00", arvalid, awvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_inflight();
    int sc, hs; logic [31:0] ar; bit bad, tmo;
    run_load(32'hBFAF_8400, 32'hDEAD_BEEF, 0, 2, 3, sc, ar, hs, bad, tmo);
    en = 1'b0;
    checks++;
    if (sc != 5 || tmo) begin
      errors++; $display("FAIL flush_rd_stall got %0d tmo %0d exp 5 tmo 0", sc, tmo);
    end
    checks++;
    if (rdata_out !== 32'h5555_6666) begin
      errors++; $display("FAIL flush_rd_rdata_kept got %h exp 55556666", rdata_out);
    end
    run_load(32'hBFAF_8404, 32'h0BAD_F00D, 0, 0, -1, sc, ar, hs, bad, tmo);
    en = 1'b0;
    checks++;
    if (rdata_out !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL post_flush_rdata got %h exp 0badf00d", rdata_out);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; wen = 4'hF; addr = 32'hBFAF_0020; wdata_in = 32'h7777_8888;
    awready = 1'b0; wready = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    #1;
    checks++;
    if (awvalid !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got aw %b stall %b exp 1 1", awvalid, stall);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, stall} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_clear got %b exp 000000",
                         {arvalid, awvalid, wvalid, rready, bready, stall});
    end
    checks++;
    if (rdata_out !== 32'h0) begin
      errors++; $display("FAIL rst_mid_rdata got %h exp 00000000", rdata_out);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (awvalid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle got aw %b stall %b exp 0 0", awvalid, stall);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; en = 1'b0; wen = '0; addr = '0; wdata_in = '0;
    arready = 1'b0; rid = 4'd1; rdata = '0; rresp = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = '0; bvalid = 1'b0;
    test_reset();
    #20;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    test_load_basic();
    test_load_delayed();
    test_store_byte();
    test_store_same_cycle();
    test_held_en();
    test_back_to_back();
    test_flush_idle();
    test_flush_inflight();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
